// File: rtl/pc_gen_pkg.sv
// Shared types and helpers for the fetch-stage next-PC generator.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    S_BOOT   = 2'd0,
    S_RUN    = 2'd1,
    S_BUBBLE = 2'd2
  } pc_state_e;

  localparam int PC_STEP_32 = 4;
  localparam int PC_STEP_16 = 2;

  // Without the C extension every target must be word aligned.
  function automatic logic is_misaligned(input logic c_ext, input logic addr_bit1);
    return !c_ext && addr_bit1;
  endfunction

endpackage

// File: rtl/pc_gen_next.sv
// Combinational redirect priority mux and PC incrementer.
module pc_gen_next
  import pc_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter bit C_EXT = 1'b0
) (
  input  logic [XLEN-1:0] pc,
  input  logic            advance,
  input  logic            compressed,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_vec,
  output logic [XLEN-1:0] next_pc,
  output logic            take_redirect,
  output logic            misaligned
);

  localparam logic [XLEN-1:0] HALF_MASK = ~XLEN'(1);

  logic [XLEN-1:0] step;

  assign step = (C_EXT && compressed) ? XLEN'(PC_STEP_16) : XLEN'(PC_STEP_32);

  // Trap beats branch; a rejected branch leaves the PC untouched.
  always_comb begin
    next_pc       = pc;
    take_redirect = 1'b0;
    misaligned    = 1'b0;
    if (trap) begin
      next_pc       = trap_vec & HALF_MASK;
      take_redirect = 1'b1;
    end else if (br_taken) begin
      if (is_misaligned(C_EXT, br_target[1])) begin
        misaligned = 1'b1;
      end else begin
        next_pc       = br_target & HALF_MASK;
        take_redirect = 1'b1;
      end
    end else if (advance) begin
      next_pc = pc + step;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC register with boot/run/bubble FSM and post-redirect flush window.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              XLEN             = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR     = '0,
  parameter bit              C_EXT            = 1'b0,
  parameter int              REDIRECT_BUBBLES = 1
) (
  input  logic            ip_clk,
  input  logic            ip_rst_n,
  input  logic            ip_stall,
  input  logic            ip_fetch_ready,
  input  logic            ip_compressed,
  input  logic            ip_br_taken,
  input  logic [XLEN-1:0] ip_br_target,
  input  logic            ip_trap,
  input  logic [XLEN-1:0] ip_trap_vec,
  output logic [XLEN-1:0] op_pc,
  output logic            op_pc_valid,
  output logic            op_flush,
  output logic            op_misaligned
);

  localparam logic [2:0] BUBBLE_LOAD = 3'(REDIRECT_BUBBLES);

  pc_state_e       state, state_nxt;
  logic [2:0]      bub_cnt, bub_cnt_nxt;
  logic [XLEN-1:0] next_pc;
  logic            take_redirect;
  logic            misaligned;
  logic            advance;

  assign advance = (state == S_RUN) && op_pc_valid && ip_fetch_ready && !ip_stall;

  pc_gen_next #(
    .XLEN  (XLEN),
    .C_EXT (C_EXT)
  ) u_next (
    .pc            (op_pc),
    .advance       (advance),
    .compressed    (ip_compressed),
    .br_taken      (ip_br_taken),
    .br_target     (ip_br_target),
    .trap          (ip_trap),
    .trap_vec      (ip_trap_vec),
    .next_pc       (next_pc),
    .take_redirect (take_redirect),
    .misaligned    (misaligned)
  );

  // A rejected branch freezes the bubble count just like a stall does.
  always_comb begin
    state_nxt   = state;
    bub_cnt_nxt = bub_cnt;
    if (take_redirect) begin
      state_nxt   = S_BUBBLE;
      bub_cnt_nxt = BUBBLE_LOAD;
    end else begin
      case (state)
        S_BOOT:  state_nxt = S_RUN;
        S_RUN:   state_nxt = S_RUN;
        S_BUBBLE: begin
          if (!misaligned && !ip_stall) begin
            if (bub_cnt <= 3'd1) begin
              state_nxt = S_RUN;
            end else begin
              bub_cnt_nxt = bub_cnt - 3'd1;
            end
          end
        end
        default: state_nxt = S_BOOT;
      endcase
    end
  end

  always_ff @(posedge ip_clk) begin
    if (!ip_rst_n) begin
      state         <= S_BOOT;
      bub_cnt       <= 3'd0;
      op_pc         <= RESET_VECTOR;
      op_pc_valid   <= 1'b0;
      op_flush      <= 1'b0;
      op_misaligned <= 1'b0;
    end else begin
      state         <= state_nxt;
      bub_cnt       <= bub_cnt_nxt;
      op_pc         <= next_pc;
      op_pc_valid   <= (state_nxt == S_RUN);
      op_flush      <= (state_nxt == S_BUBBLE);
      op_misaligned <= misaligned;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed and randomized bench for pc_gen, with and without the C extension.
module tb_pc_gen;

  localparam logic [31:0] RV = 32'h0000_0100;
  localparam int          RB = 2;

  logic        ip_clk;
  logic        ip_rst_n;
  logic        ip_stall;
  logic        ip_fetch_ready;
  logic        ip_compressed;
  logic        ip_br_taken;
  logic [31:0] ip_br_target;
  logic        ip_trap;
  logic [31:0] ip_trap_vec;

  logic [31:0] pc_o   [2];
  logic        valid_o[2];
  logic        flush_o[2];
  logic        mis_o  [2];

  int checks = 0;
  int errors = 0;

  // Reference state: remaining flush cycles rather than an FSM.
  logic [31:0] m_pc   [2];
  int          m_left [2];
  bit          m_boot [2];
  bit          m_valid[2];
  bit          m_flush[2];
  bit          m_mis  [2];

  pc_gen #(.XLEN(32), .RESET_VECTOR(RV), .C_EXT(1'b0), .REDIRECT_BUBBLES(RB)) dut_c0 (
    .ip_clk(ip_clk), .ip_rst_n(ip_rst_n), .ip_stall(ip_stall),
    .ip_fetch_ready(ip_fetch_ready), .ip_compressed(ip_compressed),
    .ip_br_taken(ip_br_taken), .ip_br_target(ip_br_target),
    .ip_trap(ip_trap), .ip_trap_vec(ip_trap_vec),
    .op_pc(pc_o[0]), .op_pc_valid(valid_o[0]), .op_flush(flush_o[0]),
    .op_misaligned(mis_o[0])
  );

  pc_gen #(.XLEN(32), .RESET_VECTOR(RV), .C_EXT(1'b1), .REDIRECT_BUBBLES(RB)) dut_c1 (
    .ip_clk(ip_clk), .ip_rst_n(ip_rst_n), .ip_stall(ip_stall),
    .ip_fetch_ready(ip_fetch_ready), .ip_compressed(ip_compressed),
    .ip_br_taken(ip_br_taken), .ip_br_target(ip_br_target),
    .ip_trap(ip_trap), .ip_trap_vec(ip_trap_vec),
    .op_pc(pc_o[1]), .op_pc_valid(valid_o[1]), .op_flush(flush_o[1]),
    .op_misaligned(mis_o[1])
  );

  initial ip_clk = 1'b0;
  always #5 ip_clk = ~ip_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input int k);
    bit cext;
    cext = (k == 1);
    m_mis[k] = 1'b0;
    if (!ip_rst_n) begin
      m_pc[k] = RV; m_boot[k] = 1'b1; m_left[k] = 0;
    end else if (ip_trap) begin
      m_pc[k] = {ip_trap_vec[31:1], 1'b0}; m_left[k] = RB; m_boot[k] = 1'b0;
    end else if (ip_br_taken && !cext && ip_br_target[1]) begin
      m_mis[k] = 1'b1; m_boot[k] = 1'b0;
    end else if (ip_br_taken) begin
      m_pc[k] = {ip_br_target[31:1], 1'b0}; m_left[k] = RB; m_boot[k] = 1'b0;
    end else if (m_boot[k]) begin
      m_boot[k] = 1'b0;
    end else if (m_left[k] > 0) begin
      if (!ip_stall) m_left[k] = m_left[k] - 1;
    end else if (ip_fetch_ready && !ip_stall) begin
      m_pc[k] = m_pc[k] + ((cext && ip_compressed) ? 32'd2 : 32'd4);
    end
    m_valid[k] = ip_rst_n && !m_boot[k] && (m_left[k] == 0);
    m_flush[k] = ip_rst_n && (m_left[k] > 0);
  endtask

  task automatic step();
    @(posedge ip_clk);
    model_update(0);
    model_update(1);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("c%0d.pc", k),    pc_o[k],           m_pc[k]);
      chk($sformatf("c%0d.valid", k), 32'(valid_o[k]),   32'(m_valid[k]));
      chk($sformatf("c%0d.flush", k), 32'(flush_o[k]),   32'(m_flush[k]));
      chk($sformatf("c%0d.mis", k),   32'(mis_o[k]),     32'(m_mis[k]));
    end
  endtask

  task automatic idle();
    ip_rst_n = 1'b1; ip_stall = 1'b0; ip_fetch_ready = 1'b1; ip_compressed = 1'b0;
    ip_br_taken = 1'b0; ip_br_target = '0; ip_trap = 1'b0; ip_trap_vec = '0;
  endtask

  initial begin
    idle();
    ip_rst_n = 1'b0;
    repeat (3) step();
    chk("rst_pc", pc_o[0], RV);
    chk("rst_valid", 32'(valid_o[0]), 32'd0);
    chk("rst_flush", 32'(flush_o[0]), 32'd0);

    ip_rst_n = 1'b1;
    step();
    chk("boot_valid", 32'(valid_o[0]), 32'd1);
    chk("boot_pc", pc_o[0], 32'h100);
    step();
    chk("run_pc1", pc_o[0], 32'h104);
    step();
    chk("run_pc2", pc_o[0], 32'h108);

    ip_br_taken = 1'b1; ip_br_target = 32'h200;
    step();
    ip_br_taken = 1'b0;
    step();
    step();
    chk("stall_start", pc_o[0], 32'h200);
    ip_stall = 1'b1;
    step();
    step();
    chk("stall_hold", pc_o[0], 32'h200);
    ip_stall = 1'b0; ip_fetch_ready = 1'b0;
    step();
    chk("notready_hold", pc_o[0], 32'h200);
    ip_fetch_ready = 1'b1;
    step();
    chk("release_pc", pc_o[0], 32'h204);

    ip_br_taken = 1'b1; ip_br_target = 32'h400;
    step();
    chk("br_pc", pc_o[0], 32'h400);
    chk("br_flush1", 32'(flush_o[0]), 32'd1);
    ip_br_taken = 1'b0;
    step();
    chk("br_flush2", 32'(flush_o[0]), 32'd1);
    step();
    chk("br_valid", 32'(valid_o[0]), 32'd1);
    chk("br_flush_end", 32'(flush_o[0]), 32'd0);
    step();
    chk("br_next", pc_o[0], 32'h404);

    ip_trap = 1'b1; ip_trap_vec = 32'h80; ip_br_taken = 1'b1; ip_br_target = 32'h400; ip_stall = 1'b1;
    step();
    chk("prio_pc", pc_o[0], 32'h80);
    chk("prio_flush", 32'(flush_o[0]), 32'd1);
    idle();
    step();
    ip_br_taken = 1'b1; ip_br_target = 32'h500;
    step();
    chk("rebr_pc", pc_o[0], 32'h500);
    ip_br_taken = 1'b0;
    step();
    chk("rebr_flush", 32'(flush_o[0]), 32'd1);
    step();
    chk("rebr_valid", 32'(valid_o[0]), 32'd1);

    ip_br_taken = 1'b1; ip_br_target = 32'h402;
    step();
    chk("mis_c0_pulse", 32'(mis_o[0]), 32'd1);
    chk("mis_c0_pc", pc_o[0], 32'h500);
    chk("mis_c0_flush", 32'(flush_o[0]), 32'd0);
    chk("mis_c1_pc", pc_o[1], 32'h402);
    ip_br_taken = 1'b0;
    step();
    chk("mis_c0_drop", 32'(mis_o[0]), 32'd0);
    step();
    ip_compressed = 1'b1;
    step();
    chk("c16_step", pc_o[1], 32'h404);
    ip_compressed = 1'b0;
    step();
    chk("c32_step", pc_o[1], 32'h408);

    ip_br_taken = 1'b1; ip_br_target = 32'hFFFF_FFFC;
    step();
    ip_br_taken = 1'b0;
    step();
    step();
    chk("wrap_top", pc_o[0], 32'hFFFF_FFFC);
    step();
    chk("wrap_zero", pc_o[0], 32'h0);

    ip_br_taken = 1'b1; ip_br_target = 32'h600;
    step();
    ip_br_taken = 1'b0; ip_rst_n = 1'b0;
    step();
    chk("rstbub_pc", pc_o[0], RV);
    chk("rstbub_flush", 32'(flush_o[0]), 32'd0);
    chk("rstbub_valid", 32'(valid_o[0]), 32'd0);
    ip_rst_n = 1'b1;
    step();

    for (int i = 0; i < 500; i++) begin
      ip_rst_n       = ($urandom_range(0, 59) != 0);
      ip_stall       = ($urandom_range(0, 3) == 0);
      ip_fetch_ready = ($urandom_range(0, 3) != 0);
      ip_compressed  = 1'($urandom);
      ip_br_taken    = ($urandom_range(0, 7) == 0);
      ip_br_target   = $urandom;
      ip_trap        = ($urandom_range(0, 15) == 0);
      ip_trap_vec    = $urandom;
      step();
    end
    idle();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised next-PC generator for the fetch stage; next generation of the PC/incrementer register. Holds the architectural fetch PC, advances it by 4 (or by 2 for compressed instructions), and redirects on trap or taken branch/jump. Honours hazard-unit stalls and a fetch-side ready handshake. After every redirect it inserts a configurable flush window so the pipeline can squash wrong-path instructions.

## Interface
- XLEN, 32: PC width in bits.
- RESET_VECTOR, 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.
- C_EXT, 0: 1 enables 16-bit instruction stepping and 2-byte target alignment.
- REDIRECT_BUBBLES, 1: flush cycles after a redirect; legal range 1..7.

- ip_clk  in  1  clock; all state changes on rising edge.
- ip_rst_n  in  1  synchronous, active-low reset.
- ip_stall  in  1  hazard-unit stall; PC holds while high.
- ip_fetch_ready  in  1  fetch accepts op_pc this cycle.
- ip_compressed  in  1  instruction at op_pc is 16-bit; ignored when C_EXT=0.
- ip_br_taken  in  1  taken branch/jump from EX.
- ip_br_target  in  XLEN  branch/jump target.
- ip_trap  in  1  trap/exception redirect request.
- ip_trap_vec  in  XLEN  trap handler address.
- op_pc  out  XLEN  current fetch PC.
- op_pc_valid  out  1  op_pc is a valid fetch request.
- op_flush  out  1  squash younger in-flight instructions.
- op_misaligned  out  1  one-cycle pulse: ip_br_target was rejected as misaligned.

## Operation
- States: S_BOOT, S_RUN, S_BUBBLE.
- Reset (ip_rst_n=0 at an edge) sets state S_BOOT and the outputs op_pc=RESET_VECTOR, op_pc_valid=0, op_flush=0, op_misaligned=0. The bubble counter is set to 0.
- S_BOOT lasts one cycle, then moves to S_RUN with op_pc_valid=1. A redirect taken in S_BOOT is handled as it is in S_RUN.
- Events in priority order: reset > trap > branch > stall > advance.
- Trap: op_pc<=ip_trap_vec with bit0 forced to 0; enter S_BUBBLE; counter<=REDIRECT_BUBBLES.
- Branch, aligned: op_pc<=ip_br_target with bit0 forced to 0; enter S_BUBBLE; counter<=REDIRECT_BUBBLES.
- Alignment rule: a target is misaligned when C_EXT=0 and bit1=1.
- Branch, misaligned: op_pc holds, state is unchanged, and op_misaligned pulses. The trap unit is expected to answer with ip_trap.
- Stall: a redirect overrides a stall. A stall alone holds op_pc, state and counter.
- Advance happens in S_RUN when op_pc_valid && ip_fetch_ready && !ip_stall. The step is 2 if C_EXT && ip_compressed, otherwise 4.
- Advance arithmetic is modulo 2^XLEN: XLEN'hFFFF_FFFC+4 wraps to 0 with no flag.
- S_BUBBLE: op_pc_valid=0 and op_flush=1. The counter decrements each non-stalled cycle; when it reaches 1, the next state is S_RUN.
- A redirect while in S_BUBBLE reloads op_pc and restarts the counter.
- Reset asserted mid-bubble or mid-stall wins unconditionally.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- Redirect sampled at edge N:
  - op_pc=target from N+1.
  - op_flush=1 for cycles N+1..N+REDIRECT_BUBBLES.
  - op_pc_valid=1 from N+1+REDIRECT_BUBBLES (plus any stalled cycles).
- Advance latency is 1 cycle: the new op_pc is visible after the accepting edge.
- op_pc is stable while op_pc_valid=1 and ip_fetch_ready=0.
- Reset released at edge K: op_pc_valid=1 from K+1.

## Structure
- Package pc_gen_pkg holds:
  - state enum {S_BOOT, S_RUN, S_BUBBLE};
  - step constants PC_STEP_32=4 and PC_STEP_16=2;
  - misalignment check function.
- Sub-module pc_gen_next: combinational priority mux plus incrementer that produces next_pc, take_redirect and misaligned. The top level holds the FSM, counter and output registers.

## Test plan
- Reset and boot: hold ip_rst_n=0 for 3 cycles with RESET_VECTOR=32'h100, then release.
  - op_pc=0x100, valid=0 for one cycle, then valid=1.
  - With ready held high, op_pc steps 0x104, 0x108, …
- Stall versus ready at op_pc=0x200:
  - ip_stall=1 for 2 cycles: PC holds at 0x200.
  - ip_fetch_ready=0: PC holds at 0x200.
  - Both released: next value is 0x204.
- Branch with REDIRECT_BUBBLES=2 at edge N, target 0x400:
  - op_pc=0x400 at N+1.
  - op_flush=1 at N+1 and N+2.
  - valid=1 at N+3.
  - op_pc=0x404 after the next accept.
- Priority at a single edge: ip_trap (vec 0x80) + ip_br_taken (0x400) + ip_stall all asserted.
  - op_pc=0x80 and op_flush=1.
  - A second branch to 0x500 issued mid-bubble sets op_pc=0x500 and restarts the counter.
- Alignment and compressed stepping:
  - C_EXT=0, target 0x402: op_misaligned pulses, PC unchanged, no flush.
  - C_EXT=1, target 0x402: accepted; with ip_compressed=1 the PC steps 0x402, 0x404; with ip_compressed=0 the next step is +4.
- Wrap-around and reset mid-bubble:
  - PC 0xFFFF_FFFC advances to 0x0.
  - ip_rst_n=0 during S_BUBBLE restores RESET_VECTOR with flush=0 and valid=0.
